// File: rtl/cpu_host_pkg.sv
// Shared definitions for the CPU host controller: FSM state encoding,
// CTRL register bit positions and control-page register offsets.
package cpu_host_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_RESET,
    ST_RUN,
    ST_HOLD,
    ST_STEP
  } host_state_e;

  localparam int CTRL_RST  = 0;
  localparam int CTRL_LOAD = 1;
  localparam int CTRL_HALT = 2;
  localparam int CTRL_STEP = 3;

  localparam logic [23:0] OFS_CTRL = 24'h000000;
  localparam logic [23:0] OFS_DIV  = 24'h000001;

endpackage

// File: rtl/cpu_host_ctrl_clk_en_div.sv
// Programmable clock-enable divider: one-cycle pulse every div+1 cycles
// while enabled; div=0 yields a continuous enable.
module clk_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             reload,
  input  logic             enable,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt;

  // The counter free-runs in every state so the pulse phase is independent
  // of when the CPU is allowed to see it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (reload || cnt >= div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign clk_en = enable && (cnt == div);

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host-side CPU controller: power-up/reset sequencing, run/halt/load control,
// clock-enable divider and host memory loading. Define CPU_SINGLE_STEP_EN to
// build the single-step feature (STEP state and CTRL bit3).
module cpu_host_ctrl
  import cpu_host_pkg::*;
#(
  parameter int         RESET_CYCLES = 65535,
  parameter int         N_REGIONS    = 2,
  parameter logic [7:0] CTRL_PAGE    = 8'hFF,
  parameter int         DIV_W        = 8,
  parameter int         DEFAULT_DIV  = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn_reset_n,
  input  logic                 spi_wr,
  input  logic [31:0]          spi_addr,
  input  logic [7:0]           spi_data,
  output logic                 cpu_reset_n,
  output logic                 cpu_clk_en,
  output logic                 cpu_wait_n,
  output logic                 loading,
  output logic [N_REGIONS-1:0] mem_we,
  output logic [23:0]          mem_addr,
  output logic [7:0]           mem_din,
  output logic [7:0]           ctrl_q,
  output logic [DIV_W-1:0]     div_q
);

  localparam int PW_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
`ifdef CPU_SINGLE_STEP_EN
  localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_WMASK = 8'hF7;
`endif

  host_state_e         state, state_nxt;
  logic [PW_W-1:0]     pw_cnt;
  logic [1:0]          btn_sync;
  logic [N_REGIONS-1:0] mem_we_nxt;

  logic [7:0]  page;
  logic [23:0] ofs;
  logic        ctrl_wr, div_wr, mem_hit;
  logic        reset_src, load, halt, run_ok, pw_done;
`ifdef CPU_SINGLE_STEP_EN
  logic        step;
  assign step = ctrl_q[CTRL_STEP];
`endif

  assign page      = spi_addr[31:24];
  assign ofs       = spi_addr[23:0];
  assign ctrl_wr   = spi_wr && (page == CTRL_PAGE) && (ofs == OFS_CTRL);
  assign div_wr    = spi_wr && (page == CTRL_PAGE) && (ofs == OFS_DIV);
  assign load      = ctrl_q[CTRL_LOAD];
  assign halt      = ctrl_q[CTRL_HALT];
  assign reset_src = ctrl_q[CTRL_RST] || !btn_sync[1];
  assign pw_done   = (pw_cnt == PW_W'(RESET_CYCLES - 1));
  // Memory writes are dropped while any reset source is active so an abort
  // mid-load cannot corrupt the image.
  assign mem_hit   = spi_wr && load && !reset_src && (page != CTRL_PAGE)
                     && (int'(page) < N_REGIONS);

  // Button is treated as pressed until two clean samples have been taken.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], btn_reset_n};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      div_q  <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (ctrl_wr) begin
        ctrl_q <= spi_data & CTRL_WMASK;
      end else begin
        ctrl_q[CTRL_STEP] <= 1'b0;
      end
      if (div_wr) begin
        div_q <= DIV_W'(spi_data);
      end
    end
  end

  always_comb begin
    mem_we_nxt = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      mem_we_nxt[i] = mem_hit && (int'(page) == i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_we <= mem_we_nxt;
      if (mem_hit) begin
        mem_addr <= ofs;
        mem_din  <= spi_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_PWRUP;
      pw_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_PWRUP) begin
        pw_cnt <= pw_cnt + 1'b1;
      end
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRUP: if (pw_done) state_nxt = ST_RESET;
      ST_RESET: if (!reset_src) state_nxt = ST_RUN;
      ST_RUN: begin
        if (reset_src)          state_nxt = ST_RESET;
        else if (load || halt)  state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (reset_src)              state_nxt = ST_RESET;
        else if (!load && !halt)    state_nxt = ST_RUN;
`ifdef CPU_SINGLE_STEP_EN
        else if (step && !load)     state_nxt = ST_STEP;
`endif
      end
      ST_STEP: begin
        if (reset_src)                 state_nxt = ST_RESET;
        else if (load || cpu_clk_en)   state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  // The enable is withheld in the cycle the FSM is about to leave RUN/STEP.
  assign run_ok = !reset_src && !load
                  && (((state == ST_RUN) && !halt) || (state == ST_STEP));

  clk_en_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (div_q),
    .reload  (div_wr),
    .enable  (run_ok),
    .clk_en  (cpu_clk_en)
  );

  assign cpu_reset_n = (state == ST_RUN) || (state == ST_HOLD) || (state == ST_STEP);
  assign cpu_wait_n  = !((state == ST_HOLD) && load);
  assign loading     = load;

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Self-checking bench for cpu_host_ctrl: cycle-level behavioural model with
// per-cycle comparison, randomized host traffic and directed scenario checks.
module tb_cpu_host_ctrl;

  localparam int         RC   = 16;
  localparam int         NR   = 2;
  localparam int         DW   = 8;
  localparam int         DDIV = 6;
  localparam logic [7:0] CP   = 8'hFF;
`ifdef CPU_SINGLE_STEP_EN
  localparam bit         STEP_ON = 1'b1;
  localparam logic [7:0] M_MASK  = 8'hFF;
`else
  localparam bit         STEP_ON = 1'b0;
  localparam logic [7:0] M_MASK  = 8'hF7;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn_reset_n = 1'b1;
  logic          spi_wr = 1'b0;
  logic [31:0]   spi_addr = '0;
  logic [7:0]    spi_data = '0;
  logic          cpu_reset_n, cpu_clk_en, cpu_wait_n, loading;
  logic [NR-1:0] mem_we;
  logic [23:0]   mem_addr;
  logic [7:0]    mem_din, ctrl_q;
  logic [DW-1:0] div_q;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_host_ctrl #(
    .RESET_CYCLES (RC),
    .N_REGIONS    (NR),
    .CTRL_PAGE    (CP),
    .DIV_W        (DW),
    .DEFAULT_DIV  (DDIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_reset_n (btn_reset_n),
    .spi_wr      (spi_wr),
    .spi_addr    (spi_addr),
    .spi_data    (spi_data),
    .cpu_reset_n (cpu_reset_n),
    .cpu_clk_en  (cpu_clk_en),
    .cpu_wait_n  (cpu_wait_n),
    .loading     (loading),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .ctrl_q      (ctrl_q),
    .div_q       (div_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {MD_PWRUP, MD_RESET, MD_RUN, MD_HOLD, MD_STEP} mode_e;

  mode_e         m_mode;
  int            m_edges;
  int            m_since;
  logic [7:0]    m_ctrl, m_div, m_din;
  logic [NR-1:0] m_we;
  logic [23:0]   m_addr;
  bit            m_b1, m_b2;

  function automatic void model_reset();
    m_mode  = MD_PWRUP;
    m_edges = 0;
    m_since = 0;
    m_ctrl  = '0;
    m_div   = 8'(DDIV);
    m_we    = '0;
    m_addr  = '0;
    m_din   = '0;
    m_b1    = 1'b0;
    m_b2    = 1'b0;
  endfunction

  function automatic bit m_src();
    return m_ctrl[0] || !m_b2;
  endfunction

  // The enable falls on the last cycle of each (div+1)-cycle period since reload.
  function automatic bit m_en();
    bit tc = ((m_since % (int'(m_div) + 1)) == int'(m_div));
    return tc && !m_src() && !m_ctrl[1]
           && (((m_mode == MD_RUN) && !m_ctrl[2]) || (m_mode == MD_STEP));
  endfunction

  task automatic compare_outputs();
    bit released = (m_mode == MD_RUN) || (m_mode == MD_HOLD) || (m_mode == MD_STEP);
    check("cpu_reset_n", 32'(cpu_reset_n), 32'(released));
    check("cpu_clk_en",  32'(cpu_clk_en),  32'(m_en()));
    check("cpu_wait_n",  32'(cpu_wait_n),  32'(!((m_mode == MD_HOLD) && m_ctrl[1])));
    check("loading",     32'(loading),     32'(m_ctrl[1]));
    check("ctrl_q",      32'(ctrl_q),      32'(m_ctrl));
    check("div_q",       32'(div_q),       32'(m_div));
    check("mem_we",      32'(mem_we),      32'(m_we));
    check("mem_addr",    32'(mem_addr),    32'(m_addr));
    check("mem_din",     32'(mem_din),     32'(m_din));
  endtask

  task automatic model_advance();
    bit         rs = m_src();
    bit         en = m_en();
    bit         ld = m_ctrl[1];
    bit         hl = m_ctrl[2];
    bit         st = m_ctrl[3];
    logic [7:0] pg = spi_addr[31:24];
    logic [23:0] of = spi_addr[23:0];
    mode_e      nm = m_mode;
    case (m_mode)
      MD_PWRUP: if (m_edges + 1 == RC) nm = MD_RESET;
      MD_RESET: if (!rs) nm = MD_RUN;
      MD_RUN:   if (rs) nm = MD_RESET; else if (ld || hl) nm = MD_HOLD;
      MD_HOLD: begin
        if (rs) nm = MD_RESET;
        else if (!ld && !hl) nm = MD_RUN;
        else if (STEP_ON && st && !ld) nm = MD_STEP;
      end
      MD_STEP:  if (rs) nm = MD_RESET; else if (ld || en) nm = MD_HOLD;
      default:  nm = MD_RESET;
    endcase
    m_edges++;
    m_we = '0;
    if (spi_wr && ld && !rs && pg != CP && int'(pg) < NR) begin
      for (int i = 0; i < NR; i++) m_we[i] = (int'(pg) == i);
      m_addr = of;
      m_din  = spi_data;
    end
    if (spi_wr && pg == CP && of == 24'h0) m_ctrl = spi_data & M_MASK;
    else m_ctrl[3] = 1'b0;
    if (spi_wr && pg == CP && of == 24'h1) begin
      m_div   = spi_data;
      m_since = 0;
    end else begin
      m_since++;
    end
    m_b2   = m_b1;
    m_b1   = btn_reset_n;
    m_mode = nm;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset();
      compare_outputs();
      if (reset_n) model_advance();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [7:0] d);
    spi_wr   = 1'b1;
    spi_addr = a;
    spi_data = d;
    tick();
    spi_wr   = 1'b0;
    spi_addr = $urandom;
    spi_data = 8'($urandom);
  endtask

  int         rise, t1, t2, cnt;
  logic [15:0] mask;
  logic [7:0] d;
  bit         seen;

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_ctrl_q", 32'(ctrl_q), 32'h0);
    check("reset_div_q", 32'(div_q), 32'(DDIV));
    check("reset_wait_n", 32'(cpu_wait_n), 32'h1);
    reset_n = 1'b1;

    // power-up release and run cadence
    rise = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      tick();
      if (cpu_reset_n) rise = i;
    end
    check("pwrup_release_17_to_19", 32'(rise >= 17 && rise <= 19), 32'h1);
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 30 && t2 < 0; i++) begin
      tick();
      if (cpu_clk_en) begin
        if (t1 < 0) t1 = i;
        else t2 = i;
      end
    end
    check("run_pulse_spacing", 32'(t2 - t1), 32'd7);

    // host load
    host_write(32'hFF00_0000, 8'h02);
    host_write(32'h0100_0123, 8'hAB);
    check("load_mem_we", 32'(mem_we), 32'h2);
    check("load_mem_addr", 32'(mem_addr), 32'h000123);
    check("load_mem_din", 32'(mem_din), 32'hAB);
    tick();
    check("load_we_one_cycle", 32'(mem_we), 32'h0);
    check("load_wait_n", 32'(cpu_wait_n), 32'h0);
    host_write(32'h0200_0000, 8'h55);
    check("bad_page_dropped", 32'(mem_we), 32'h0);
    host_write(32'h0000_0010, 8'h3C);
    check("page0_mem_we", 32'(mem_we), 32'h1);
    host_write(32'hFF00_0005, 8'h77);
    check("ctrl_page_other_ignored", 32'(ctrl_q), 32'h02);

    // divider
    host_write(32'hFF00_0000, 8'h00);
    host_write(32'hFF00_0001, 8'h00);
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt += int'(cpu_clk_en);
    end
    check("div0_continuous", 32'(cnt), 32'd8);
    host_write(32'hFF00_0001, 8'h03);
    mask = '0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      mask[k] = cpu_clk_en;
    end
    check("div3_pulse_pattern", 32'(mask), 32'h8888);

    // single step
    host_write(32'hFF00_0001, 8'h06);
    host_write(32'hFF00_0000, 8'h04);
    repeat (3) tick();
    cnt = 0;
    for (int s = 0; s < 3; s++) begin
      host_write(32'hFF00_0000, 8'h0C);
      cnt += int'(cpu_clk_en);
      repeat (12) begin
        tick();
        cnt += int'(cpu_clk_en);
      end
    end
    check("step_pulse_count", 32'(cnt), STEP_ON ? 32'd3 : 32'd0);
    check("step_self_clear", 32'(ctrl_q), 32'h04);

    // button abort during load
    host_write(32'hFF00_0000, 8'h02);
    repeat (2) tick();
    check("abort_pre_wait_n", 32'(cpu_wait_n), 32'h0);
    btn_reset_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      if (!cpu_reset_n) seen = 1'b1;
    end
    check("abort_within_3", 32'(seen), 32'h1);
    for (int i = 0; i < 4; i++) begin
      host_write({8'(i % NR), 24'h000040 + 24'(i)}, 8'(i));
      check("abort_mem_we_blocked", 32'(mem_we), 32'h0);
    end
    btn_reset_n = 1'b1;
    repeat (4) tick();
    host_write(32'h0100_0042, 8'h99);
    check("after_release_mem_we", 32'(mem_we), 32'h2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) btn_reset_n = ~btn_reset_n;
      case ($urandom_range(0, 5))
        0: begin
          d = 8'($urandom);
          if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
          host_write(32'hFF00_0000, d);
        end
        1: host_write(32'hFF00_0001, 8'($urandom_range(0, 5)));
        2: host_write({8'hFF, 24'($urandom_range(2, 15))}, 8'($urandom));
        3, 4: host_write({8'($urandom_range(0, 3)), 24'($urandom)}, 8'($urandom));
        default: tick();
      endcase
    end
    btn_reset_n = 1'b1;
    host_write(32'hFF00_0000, 8'h00);
    host_write(32'hFF00_0001, 8'h06);
    repeat (10) tick();

    // host writes accepted during power-up, release still waits
    reset_n = 1'b0;
    tick();
    check("rerst_ctrl_q", 32'(ctrl_q), 32'h0);
    reset_n = 1'b1;
    host_write(32'hFF00_0000, 8'h04);
    host_write(32'hFF00_0001, 8'h02);
    check("pwrup_ctrl_accept", 32'(ctrl_q), 32'h04);
    check("pwrup_div_accept", 32'(div_q), 32'h02);
    check("pwrup_still_reset", 32'(cpu_reset_n), 32'h0);
    repeat (25) tick();
    check("pwrup_halted_released", 32'(cpu_reset_n), 32'h1);
    cnt = 0;
    repeat (10) begin
      tick();
      cnt += int'(cpu_clk_en);
    end
    check("halted_no_pulses", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
